// File: rtl/btn_debounce_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_tick_pkg
// Description : Shared definitions for tick-driven button debouncing.
//               - btn_state_t : 2-bit debounce FSM state encoding
//               - DEB_MS_DEF  : default debounce window, in 1 ms ticks
//               - LONG_MS_DEF : default long-press threshold, in 1 ms ticks
//               The timing defaults are shared with the other tick consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_debounce_tick_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,   // stable low
        ST_WHI = 2'd1,   // low, waiting for a stable high
        ST_HI  = 2'd2,   // stable high
        ST_WLO = 2'd3    // high, waiting for a stable low
    } btn_state_t;

    localparam int DEB_MS_DEF  = 20;
    localparam int LONG_MS_DEF = 1000;

endpackage : btn_debounce_tick_pkg
`default_nettype wire

// File: rtl/btn_debounce_tick_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchronizer for asynchronous inputs.
//               Both stages reset to 0; output lags the input by two clocks.
// Ports       : i_clk  - destination clock
//               i_rstn - asynchronous active-low reset
//               i_d    - asynchronous input  [WIDTH-1:0]
//               o_q    - synchronized output [WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/btn_debounce_tick.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_tick
// Description : Push-button debouncer timed by a 1 ms tick strobe. The raw
//               button is synchronized, then a level change is accepted only
//               after DEB_MS consecutive ticks of a stable synchronized value.
//               Emits a clean level plus one-cycle press/release strobes and,
//               when BTN_LONG_PRESS_EN is defined, a one-cycle long-press
//               strobe LONG_MS ticks after an accepted press.
// Macro       : BTN_LONG_PRESS_EN - build the long-press logic (else o_long=0)
// Ports       : i_clk     - system clock
//               i_rstn    - asynchronous active-low reset
//               i_pls_1k  - 1 ms tick, one i_clk cycle wide
//               i_btn     - raw asynchronous button, active-high
//               o_btn_lvl - debounced level
//               o_press   - strobe on accepted 0->1
//               o_release - strobe on accepted 1->0
//               o_long    - strobe once per press after LONG_MS held ticks
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_tick
    import btn_debounce_tick_pkg::*;
#(
    parameter int DEB_MS  = DEB_MS_DEF,
    parameter int LONG_MS = LONG_MS_DEF,
    parameter int CNT_W   = 10
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_pls_1k,
    input  logic i_btn,
    output logic o_btn_lvl,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_MS - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic             w_s_btn;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] w_deb_nxt;
    logic             r_lvl;
    logic             w_lvl_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_btn),
        .o_q    (w_s_btn)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= ST_LO;
            r_deb_cnt <= '0;
            r_lvl     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_lvl     <= w_lvl_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // A bounce seen in the same cycle as a tick takes priority: the state
    // falls back and that tick is not counted.
    always_comb begin
        w_state_nxt   = r_state;
        w_deb_nxt     = r_deb_cnt;
        w_lvl_nxt     = r_lvl;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_LO: begin
                if (w_s_btn) begin
                    w_state_nxt = ST_WHI;
                    w_deb_nxt   = '0;
                end
            end
            ST_WHI: begin
                if (!w_s_btn) begin
                    w_state_nxt = ST_LO;
                end else if (i_pls_1k) begin
                    if (r_deb_cnt == c_deb_last) begin
                        w_state_nxt = ST_HI;
                        w_lvl_nxt   = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_deb_nxt = r_deb_cnt + c_one;
                    end
                end
            end
            ST_HI: begin
                if (!w_s_btn) begin
                    w_state_nxt = ST_WLO;
                    w_deb_nxt   = '0;
                end
            end
            ST_WLO: begin
                if (w_s_btn) begin
                    w_state_nxt = ST_HI;
                end else if (i_pls_1k) begin
                    if (r_deb_cnt == c_deb_last) begin
                        w_state_nxt   = ST_LO;
                        w_lvl_nxt     = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_deb_nxt = r_deb_cnt + c_one;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_LO;
                w_deb_nxt   = '0;
            end
        endcase
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_MS - 1);

    logic [CNT_W-1:0] r_long_cnt;
    logic             r_long_done;
    logic             r_long;

    // Hold time is measured while the accepted level is high (ST_HI and
    // ST_WLO). The counter stops at LONG_MS via r_long_done, so a single
    // press can only ever produce one strobe; only a new accepted press
    // re-arms it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_nxt) begin
                r_long_cnt  <= '0;
                r_long_done <= 1'b0;
            end else if (i_pls_1k && !r_long_done &&
                         (r_state == ST_HI || r_state == ST_WLO)) begin
                r_long_cnt <= r_long_cnt + c_one;
                if (r_long_cnt == c_long_last) begin
                    r_long_done <= 1'b1;
                    r_long      <= 1'b1;
                end
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

    assign o_btn_lvl = r_lvl;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : btn_debounce_tick
`default_nettype wire
